// File: rtl/jtag_apb_master_pkg.sv
// Shared types for the JTAG debug APB master: FSM states and the captured request.
// Request fields are sized for the core debug APB map (5-bit address, 32-bit data).
package jtag_apb_pkg;

  localparam int unsigned APB_STRB_WIDTH = 4;
  localparam int unsigned APB_REQ_ADDR_W = 5;
  localparam int unsigned APB_REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                      wr;
    logic [APB_REQ_ADDR_W-1:0] addr;
    logic [APB_REQ_DATA_W-1:0] wdata;
    logic [APB_STRB_WIDTH-1:0] wstrb;
  } apb_req_t;

  localparam apb_req_t REQ_RESET = '{wr: 1'b0, addr: 5'h00, wdata: 32'h0000_0000, wstrb: 4'h0};

  // Reads never drive byte lanes.
  function automatic logic [APB_STRB_WIDTH-1:0] req_strobe(input logic wr,
                                                           input logic [APB_STRB_WIDTH-1:0] wstrb);
    return wr ? wstrb : {APB_STRB_WIDTH{1'b0}};
  endfunction

endpackage

// File: rtl/jtag_apb_master_timeout_ctr.sv
// Saturating wait-state counter; flags expiry on the ACCESS cycle that would reach the limit.
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = (TIMEOUT_CYCLES == 32'd0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up without wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 32'd0) && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/jtag_apb_master.sv
// Single-outstanding APB master: one JTAG debug request in, one APB transfer out,
// one response (read data + timeout flag) back.
module jtag_apb_master
  import jtag_apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 5,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  input  logic [APB_STRB_WIDTH-1:0] req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_STRB_WIDTH-1:0] pstrb,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata
);

  state_t                    state_q, state_d;
  apb_req_t                  req_q, req_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      tmo_clr_s, tmo_en_s, tmo_expired_s;

  assign tmo_clr_s = (state_q == IDLE) && req_valid;
  assign tmo_en_s  = (state_q == ACCESS) && !pready;

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmo_clr_s),
    .en_i     (tmo_en_s),
    .expired_o(tmo_expired_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; pready is checked before expiry so a last-cycle completion succeeds
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SETUP; else state_d = IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || tmo_expired_s) state_d = RESP; else state_d = ACCESS;
      RESP:    if (rsp_ready) state_d = IDLE; else state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // handshake and APB strobes decoded from the state register
  always_comb begin
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      SETUP:   psel = 1'b1;
      ACCESS:  begin psel = 1'b1; penable = 1'b1; end
      RESP:    rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // request capture on acceptance, response capture on ACCESS exit
  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (tmo_clr_s) begin
      req_d.wr    = req_wr;
      req_d.addr  = APB_REQ_ADDR_W'(req_addr);
      req_d.wdata = req_wr ? APB_REQ_DATA_W'(req_wdata) : req_q.wdata;
      req_d.wstrb = req_strobe(req_wr, req_wstrb);
    end else if ((state_q == ACCESS) && pready) begin
      rdata_d = req_q.wr ? {APB_DATA_WIDTH{1'b0}} : prdata;
      err_d   = 1'b0;
    end else if ((state_q == ACCESS) && tmo_expired_s) begin
      rdata_d = {APB_DATA_WIDTH{1'b0}};
      err_d   = 1'b1;
    end else begin
      req_d   = req_q;
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= REQ_RESET;
      rdata_q <= {APB_DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign paddr     = APB_ADDR_WIDTH'(req_q.addr);
  assign pwrite    = req_q.wr;
  assign pwdata    = APB_DATA_WIDTH'(req_q.wdata);
  assign pstrb     = req_q.wstrb;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_jtag_apb_master.sv
// Scoreboard bench: driver pushes expected APB phases and responses, a negedge monitor
// pops and compares them; a wait-state APB slave model sits on the bus.
module tb_jtag_apb_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [4:0]  req_addr = 5'h00;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;

  always #5 clk = ~clk;

  jtag_apb_master #(.APB_ADDR_WIDTH(5), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata)
  );

  typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic [4:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; } apb_t;

  int total = 0, bad = 0, cyc = 0, issued = 0, done = 0, outstanding = 0;
  rsp_t exp_q[$];
  apb_t apb_q[$];
  int   acc_q[$];
  int   wait_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] slv_mem [32];
  bit   hold_low = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave: per-transfer wait states taken from wait_q at SETUP
  int cur_wait = 0, wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (psel && !penable) begin
      cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      wcnt = 0;
      pready = 1'b0;
    end else if (psel && penable) begin
      if (wcnt >= cur_wait) begin pready = 1'b1; prdata = slv_mem[paddr]; end
      else begin pready = 1'b0; prdata = $urandom; end
      wcnt++;
    end else begin
      pready = 1'b0;
      prdata = $urandom;
    end
  end

  always @(negedge clk) begin
    if (rst_n && psel && penable && pready && pwrite)
      for (int b = 0; b < 4; b++) if (pstrb[b]) slv_mem[paddr][8*b +: 8] = pwdata[8*b +: 8];
  end

  always @(posedge clk) begin
    #2;
    rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // monitor
  bit prev_valid = 1'b0, prev_hs = 1'b0, prev_psel = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_rdata = 32'h0;
  logic [41:0] snap = 42'h0;
  int first_cyc = 0, acc_c = 0;
  apb_t m_apb;
  rsp_t m_rsp;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        chk("accept_while_busy", outstanding, 0);
        outstanding++;
        acc_q.push_back(cyc);
      end
      if (psel && !penable) begin
        chk("setup_after_idle", prev_psel, 0);
        if (apb_q.size() == 0) chk("setup_unexpected", 1, 0);
        else begin
          m_apb = apb_q.pop_front();
          chk("paddr", paddr, m_apb.addr);
          chk("pwrite", pwrite, m_apb.wr);
          chk("pstrb", pstrb, m_apb.strb);
          if (m_apb.wr) chk("pwdata", pwdata, m_apb.wdata);
        end
        snap = {pwrite, paddr, pstrb, pwdata};
      end
      if (psel && penable) begin
        chk("access_after_setup", prev_psel, 1);
        chk("apb_stable", {pwrite, paddr, pstrb, pwdata}, snap);
      end
      if (penable && !psel) chk("penable_without_psel", 1, 0);
      if (rsp_valid) begin
        chk("rsp_phase_idle_bus", {psel, penable, req_ready}, 3'b000);
        if (!prev_valid || prev_hs) first_cyc = cyc;
        else begin
          chk("rsp_hold_rdata", rsp_rdata, prev_rdata);
          chk("rsp_hold_err", rsp_err, prev_err);
        end
        if (rsp_ready) begin
          outstanding--;
          done++;
          if (exp_q.size() == 0 || acc_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            m_rsp = exp_q.pop_front();
            acc_c = acc_q.pop_front();
            chk("rsp_rdata", rsp_rdata, m_rsp.rdata);
            chk("rsp_err", rsp_err, m_rsp.err);
            chk("rsp_latency", first_cyc - acc_c, m_rsp.lat);
          end
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
      prev_psel  = psel;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_psel  = 1'b0;
    end
  end

  // driver: w = wait states the slave inserts; w >= TMO means the transfer times out
  task automatic do_req(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int w);
    rsp_t r;
    apb_t a;
    bit ok = 1'b0;
    issued++;
    wait_q.push_back(w);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    else begin
      a.addr = addr; a.wr = wr; a.wdata = wdata; a.strb = wr ? wstrb : 4'h0;
      apb_q.push_back(a);
      r.err = (w >= TMO);
      r.lat = 2 + ((w < TMO) ? w + 1 : TMO);
      r.rdata = (wr || r.err) ? 32'h0 : ref_mem[addr];
      if (wr && !r.err)
        for (int b = 0; b < 4; b++) if (wstrb[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back(r);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 5'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #3;
      if (done == issued) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", done, issued);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[16] = 32'h1234_5678;
    slv_mem[16] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel_penable", {psel, penable, pwrite}, 3'b000);
    chk("rst_paddr_pstrb", {paddr, pstrb}, 9'h000);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;

    do_req(1'b1, 5'h04, 32'hDEAD_BEEF, 4'hF, 0);  wait_drain();
    do_req(1'b0, 5'h10, 32'h0, 4'hF, 3);          wait_drain();
    do_req(1'b0, 5'h04, 32'h0, 4'h0, 0);          wait_drain();
    do_req(1'b1, 5'h08, 32'hCAFE_F00D, 4'h5, 3);  wait_drain();
    do_req(1'b0, 5'h08, 32'h0, 4'h0, 1);          wait_drain();
    do_req(1'b1, 5'h0C, 32'h5555_AAAA, 4'hF, 4);  wait_drain();
    do_req(1'b0, 5'h0C, 32'h0, 4'h0, 0);          wait_drain();
    do_req(1'b0, 5'h10, 32'h0, 4'h0, 100);        wait_drain();

    // response backpressure with the next request already waiting
    hold_low = 1'b1;
    do_req(1'b0, 5'h04, 32'h0, 4'h0, 1);
    fork
      do_req(1'b1, 5'h14, 32'h0BAD_F00D, 4'hC, 0);
    join_none
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    repeat (5) @(posedge clk);
    hold_low = 1'b0;
    wait_drain();
    do_req(1'b0, 5'h14, 32'h0, 4'h0, 0);          wait_drain();

    // reset in the middle of a stretched ACCESS phase
    do_req(1'b0, 5'h18, 32'h0, 4'h0, 50);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (psel && penable) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_psel_penable", {psel, penable}, 2'b00);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    exp_q.delete(); apb_q.delete(); acc_q.delete(); wait_q.delete();
    outstanding = 0;
    done = issued;
    rst_n = 1'b1;
    do_req(1'b0, 5'h18, 32'h0, 4'h0, 2);          wait_drain();

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom), 5'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
